// File: rtl/csa_pkg.sv
// Shared sizing helpers and types for the carry-save summation tree.
// Elaboration-time only: level count, per-level operand count, pipeline latency.
package csa_pkg;

  localparam int DEF_W = 26;
  localparam int DEF_N = 29;

  function automatic int csa_sw(input int w, input int n);
    return w + $clog2(n);
  endfunction

  localparam int DEF_SW = csa_sw(DEF_W, DEF_N);

  typedef logic [DEF_SW-1:0] sw_vec_t;

  // Side-band that travels with every beat through the tree.
  typedef struct packed {
    logic vld;
    logic last;
    logic first;
    logic mode;
  } tag_t;

  function automatic int csa_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int csa_count(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = csa_next(c);
    return c;
  endfunction

  function automatic int csa_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = csa_next(c);
      l++;
    end
    return l;
  endfunction

  function automatic int csa_lat(input int n, input int reg_every);
    return (csa_levels(n) + reg_every - 1) / reg_every + 1;
  endfunction

  // The final level is always registered so the CPA sees a clean boundary.
  function automatic bit csa_is_reg(input int lvl, input int nlev, input int reg_every);
    return (((lvl + 1) % reg_every) == 0) || (lvl == nlev - 1);
  endfunction

endpackage

// File: rtl/csa_32.sv
// One row of SW-bit 3:2 compressors: three addends in, sum and shifted carry out.
// Purely combinational, no backpressure.
module csa_32
  import csa_pkg::*;
#(
  parameter int SW = DEF_SW
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic [SW-1:0] i_c,
  output logic [SW-1:0] o_s,
  output logic [SW-1:0] o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  // Carry out of the top bit is dropped; SW is wide enough for the true sum.
  assign o_c = {(i_a[SW-2:0] & i_b[SW-2:0]) |
                (i_a[SW-2:0] & i_c[SW-2:0]) |
                (i_b[SW-2:0] & i_c[SW-2:0]), 1'b0};

endmodule

// File: rtl/csa_tree_acc.sv
// Pipelined N-operand carry-save sum with optional multi-beat accumulate; rst_n is active-high.
// Latency csa_lat(N, REG_EVERY) cycles, one beat per cycle, no backpressure.
module csa_tree_acc
  import csa_pkg::*;
#(
  parameter int W         = 26,
  parameter int N         = 29,
  parameter int REG_EVERY = 2,
  parameter int ACC_EXT   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic           in_last,
  input  logic           acc_en,
  output logic           out_valid,
  output logic [W-1:0]   result,
  output logic           ovf
);

  localparam int SW  = csa_sw(W, N);
  localparam int L   = csa_levels(N);
  localparam int AW  = SW + ACC_EXT;
  localparam int AW1 = AW + 1;

  typedef logic [SW-1:0] sw_t;
  typedef logic [AW-1:0] acc_t;

  // Group tracking at the input.
  logic r_in_grp;
  logic r_mode;
  logic w_first;
  tag_t w_tag_in;

  assign w_first = !r_in_grp;

  always_comb begin
    w_tag_in = '0;
    if (in_valid) begin
      w_tag_in.vld   = 1'b1;
      w_tag_in.last  = in_last;
      w_tag_in.first = w_first;
      w_tag_in.mode  = w_first ? acc_en : r_mode;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_in_grp <= 1'b0;
      r_mode   <= 1'b0;
    end else if (in_valid) begin
      r_in_grp <= !in_last;
      if (w_first) r_mode <= acc_en;
    end
  end

  // Level l operands live in w_lv[l][0 .. csa_count(N,l)-1]; the rest are zero.
  sw_t  w_lv  [L+1][N];
  tag_t w_tag [L+1];

  for (genvar k = 0; k < N; k++) begin : g_in
    assign w_lv[0][k] = sw_t'(in_data[k*W +: W]);
  end
  assign w_tag[0] = w_tag_in;

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int NI = csa_count(N, l);
    localparam int NG = NI / 3;
    localparam int NO = 2 * NG + (NI % 3);

    sw_t w_nx [N];

    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa_32 #(.SW(SW)) u_csa (
        .i_a (w_lv[l][3*g]),
        .i_b (w_lv[l][3*g+1]),
        .i_c (w_lv[l][3*g+2]),
        .o_s (w_nx[2*g]),
        .o_c (w_nx[2*g+1])
      );
    end

    for (genvar k = 2 * NG; k < N; k++) begin : g_pass
      if (k < NO) begin : g_fwd
        assign w_nx[k] = w_lv[l][NG + k];
      end else begin : g_zero
        assign w_nx[k] = '0;
      end
    end

    if (csa_is_reg(l, L, REG_EVERY)) begin : g_reg
      sw_t  r_lv [N];
      tag_t r_tag;

      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          r_tag <= '0;
          for (int k = 0; k < N; k++) r_lv[k] <= '0;
        end else begin
          r_tag <= w_tag[l];
          for (int k = 0; k < N; k++) r_lv[k] <= w_nx[k];
        end
      end

      for (genvar k = 0; k < N; k++) begin : g_o
        assign w_lv[l+1][k] = r_lv[k];
      end
      assign w_tag[l+1] = r_tag;
    end else begin : g_cmb
      for (genvar k = 0; k < N; k++) begin : g_o
        assign w_lv[l+1][k] = w_nx[k];
      end
      assign w_tag[l+1] = w_tag[l];
    end
  end

  // Carry-propagate close plus accumulator.
  tag_t           w_t;
  sw_t            w_sum;
  logic [AW1-1:0] w_add;
  acc_t           r_acc;
  acc_t           w_acc_nx;
  logic           r_wrap;
  logic           w_wrap_nx;
  logic           w_emit;

  assign w_t   = w_tag[L];
  assign w_sum = w_lv[L][0] + w_lv[L][1];
  assign w_add = {1'b0, r_acc} + AW1'(w_sum);

  always_comb begin
    w_acc_nx  = r_acc;
    w_wrap_nx = r_wrap;
    if (w_t.vld && w_t.mode) begin
      if (w_t.first) begin
        w_acc_nx  = acc_t'(w_sum);
        w_wrap_nx = 1'b0;
      end else begin
        w_acc_nx  = w_add[AW-1:0];
        w_wrap_nx = r_wrap | w_add[AW];
      end
    end
  end

  assign w_emit = w_t.vld && (!w_t.mode || w_t.last);

  logic         r_out_valid;
  logic [W-1:0] r_result;
  logic         r_ovf;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_acc       <= '0;
      r_wrap      <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_acc       <= w_acc_nx;
      r_wrap      <= w_wrap_nx;
      r_out_valid <= w_emit;
      if (w_emit) begin
        if (w_t.mode) begin
          r_result <= w_acc_nx[W-1:0];
          r_ovf    <= (|w_acc_nx[AW-1:W]) | w_wrap_nx;
        end else begin
          r_result <= w_sum[W-1:0];
          r_ovf    <= |w_sum[SW-1:W];
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_csa_tree_acc.sv
// Bench: default 29x26 tree with table-driven and hand sequences, plus a 7x8 tree under random stimulus.
module tb_csa_tree_acc;

  localparam int BW    = 26;
  localparam int BN    = 29;
  localparam int SWD   = 8;
  localparam int SN    = 7;
  localparam int LAT_B = 5;  // 8 levels / 2 + CPA
  localparam int LAT_S = 5;  // 4 levels / 1 + CPA

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              b_valid, b_last, b_acc, b_ov, b_ovf;
  logic [BN*BW-1:0]  b_data;
  logic [BW-1:0]     b_res;
  logic              s_valid, s_last, s_acc, s_ov, s_ovf;
  logic [SN*SWD-1:0] s_data;
  logic [SWD-1:0]    s_res;

  csa_tree_acc dut_b (
    .clk(clk), .rst_n(rst), .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
    .acc_en(b_acc), .out_valid(b_ov), .result(b_res), .ovf(b_ovf)
  );

  csa_tree_acc #(.W(SWD), .N(SN), .REG_EVERY(1), .ACC_EXT(0)) dut_s (
    .clk(clk), .rst_n(rst), .in_valid(s_valid), .in_data(s_data), .in_last(s_last),
    .acc_en(s_acc), .out_valid(s_ov), .result(s_res), .ovf(s_ovf)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [25:0] res;
    logic        ovf;
    int          cyc;
    int          id;
  } exp_t;

  exp_t q_b[$];
  exp_t q_s[$];
  exp_t eb, es;

  typedef struct {
    logic [25:0] base;
    logic [25:0] step;
    logic        acc;
    logic [25:0] res;
    logic        ovf;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endtask

  function automatic logic [BN*BW-1:0] pat(input logic [25:0] base, input logic [25:0] step);
    logic [BN*BW-1:0] d;
    for (int k = 0; k < BN; k++) d[k*BW +: BW] = base + 26'(k) * step;
    return d;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic b_beat(input logic [BN*BW-1:0] d, input logic last, input logic acc,
                        input logic push, input logic [25:0] er, input logic eo, input int id);
    b_valid = 1'b1;
    b_data  = d;
    b_last  = last;
    b_acc   = acc;
    if (push) q_b.push_back('{res: er, ovf: eo, cyc: cyc + LAT_B, id: id});
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  // Reference group model for the small tree.
  logic sm_in_grp = 1'b0;
  logic sm_mode   = 1'b0;
  int   sm_sum    = 0;
  int   sm_id     = 1000;

  task automatic s_beat(input logic [SN*SWD-1:0] d, input logic last, input logic acc);
    int  bs;
    logic first;
    bs = 0;
    for (int k = 0; k < SN; k++) bs += int'(d[k*SWD +: SWD]);
    first = !sm_in_grp;
    if (first) sm_mode = acc;
    sm_sum = first ? bs : sm_sum + bs;
    if (!sm_mode)
      q_s.push_back('{res: 26'(bs % 256), ovf: (bs > 255), cyc: cyc + LAT_S, id: sm_id});
    else if (last)
      q_s.push_back('{res: 26'(sm_sum % 256), ovf: (sm_sum > 255), cyc: cyc + LAT_S, id: sm_id});
    sm_id++;
    sm_in_grp = !last;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_acc   = acc;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && b_ov) begin
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL big_spurious: got out_valid with result 0x%0h, required no output", b_res);
      end else begin
        eb = q_b.pop_front();
        chk($sformatf("big_result id%0d", eb.id), 64'(b_res), 64'(eb.res));
        chk($sformatf("big_ovf id%0d", eb.id), 64'(b_ovf), 64'(eb.ovf));
        chk($sformatf("big_latency id%0d", eb.id), 64'(cyc), 64'(eb.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_ov) begin
      if (q_s.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL small_spurious: got out_valid with result 0x%0h, required no output", s_res);
      end else begin
        es = q_s.pop_front();
        chk($sformatf("small_result id%0d", es.id), 64'(s_res), 64'(es.res));
        chk($sformatf("small_ovf id%0d", es.id), 64'(s_ovf), 64'(es.ovf));
        chk($sformatf("small_latency id%0d", es.id), 64'(cyc), 64'(es.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

  initial begin
    logic [SN*SWD-1:0] d;

    vt[0] = '{26'd1,        26'd0,    1'b0, 26'd29,        1'b0};
    vt[1] = '{26'h3FFFFFF,  26'd0,    1'b0, 26'h3FFFFE3,   1'b1};
    vt[2] = '{26'd0,        26'd1,    1'b0, 26'd406,       1'b0};
    vt[3] = '{26'h0100000,  26'd0,    1'b1, 26'h1D00000,   1'b0};
    vt[4] = '{26'h2000000,  26'd0,    1'b1, 26'h2000000,   1'b1};
    vt[5] = '{26'd0,        26'd0,    1'b0, 26'd0,         1'b0};
    vt[6] = '{26'h0234567,  26'h11,   1'b0, 26'h3FEF7A1,   1'b0};

    rst = 1'b1;
    b_valid = 1'b0; b_last = 1'b0; b_acc = 1'b0; b_data = '0;
    s_valid = 1'b0; s_last = 1'b0; s_acc = 1'b0; s_data = '0;
    idle(2);
    chk("reset_b_valid", 64'(b_ov), 64'd0);
    chk("reset_b_result", 64'(b_res), 64'd0);
    chk("reset_b_ovf", 64'(b_ovf), 64'd0);
    chk("reset_s_valid", 64'(s_ov), 64'd0);
    chk("reset_s_result", 64'(s_res), 64'd0);
    chk("reset_s_ovf", 64'(s_ovf), 64'd0);
    rst = 1'b0;
    idle(1);

    // Back-to-back single-beat groups from the table.
    for (int i = 0; i < 7; i++)
      b_beat(pat(vt[i].base, vt[i].step), 1'b1, vt[i].acc, 1'b1, vt[i].res, vt[i].ovf, i);
    idle(8);

    // Four-beat accumulate with a two-cycle bubble: 4 * 29 * 3.
    b_beat(pat(26'd3, 26'd0), 1'b0, 1'b1, 1'b0, 26'd0, 1'b0, 0);
    b_beat(pat(26'd3, 26'd0), 1'b0, 1'b1, 1'b0, 26'd0, 1'b0, 0);
    idle(2);
    b_beat(pat(26'd3, 26'd0), 1'b0, 1'b0, 1'b0, 26'd0, 1'b0, 0);
    b_beat(pat(26'd3, 26'd0), 1'b1, 1'b0, 1'b1, 26'd348, 1'b0, 100);
    idle(8);

    // acc_en changes mid-group are ignored; groups follow each other with no gap.
    b_beat(pat(26'd1, 26'd0), 1'b0, 1'b1, 1'b0, 26'd0, 1'b0, 0);
    b_beat(pat(26'd2, 26'd0), 1'b0, 1'b0, 1'b0, 26'd0, 1'b0, 0);
    b_beat(pat(26'd4, 26'd0), 1'b1, 1'b0, 1'b1, 26'd203, 1'b0, 101);
    b_beat(pat(26'd1, 26'd0), 1'b0, 1'b0, 1'b1, 26'd29, 1'b0, 102);
    b_beat(pat(26'd2, 26'd0), 1'b1, 1'b1, 1'b1, 26'd58, 1'b0, 103);
    b_beat(pat(26'd1, 26'd0), 1'b0, 1'b1, 1'b0, 26'd0, 1'b0, 0);
    b_beat(pat(26'd1, 26'd0), 1'b1, 1'b0, 1'b1, 26'd58, 1'b0, 104);
    b_beat(pat(26'd6, 26'd0), 1'b1, 1'b0, 1'b1, 26'd174, 1'b0, 105);
    idle(8);

    // Outputs hold, then reset mid-group clears them immediately.
    b_beat(pat(26'h3FFFFFF, 26'd0), 1'b1, 1'b0, 1'b1, 26'h3FFFFE3, 1'b1, 106);
    idle(6);
    chk("hold_valid", 64'(b_ov), 64'd0);
    chk("hold_result", 64'(b_res), 64'h3FFFFE3);
    b_beat(pat(26'd7, 26'd0), 1'b0, 1'b1, 1'b0, 26'd0, 1'b0, 0);
    b_beat(pat(26'd7, 26'd0), 1'b0, 1'b1, 1'b0, 26'd0, 1'b0, 0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(b_ov), 64'd0);
    chk("async_rst_result", 64'(b_res), 64'd0);
    chk("async_rst_ovf", 64'(b_ovf), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    b_beat(pat(26'd5, 26'd0), 1'b1, 1'b1, 1'b1, 26'd145, 1'b0, 107);
    idle(8);

    // Small tree: accumulator (11 bits) wraps to exactly zero, and the 255/256 boundary.
    d = {SN{8'hFF}};
    s_beat(d, 1'b0, 1'b1);
    d = '0; d[7:0] = 8'hFF; d[15:8] = 8'd8;
    s_beat(d, 1'b1, 1'b0);
    d = '0; d[7:0] = 8'd200;
    s_beat(d, 1'b0, 1'b1);
    d = '0; d[7:0] = 8'd55;
    s_beat(d, 1'b1, 1'b1);
    d = '0; d[7:0] = 8'd200;
    s_beat(d, 1'b0, 1'b1);
    d = '0; d[7:0] = 8'd56;
    s_beat(d, 1'b1, 1'b1);
    idle(8);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        logic wide;
        wide = ($urandom_range(0, 1) == 1);
        for (int k = 0; k < SN; k++)
          d[k*SWD +: SWD] = wide ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
        s_beat(d, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      end
    end
    for (int k = 0; k < SN; k++) d[k*SWD +: SWD] = 8'($urandom_range(0, 255));
    s_beat(d, 1'b1, 1'b0);
    idle(10);

    chk("big_queue_drained", 64'(q_b.size()), 64'd0);
    chk("small_queue_drained", 64'(q_s.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
